// File: rtl/knn_pkg.sv
// Shared widths and FSM encoding for the k-NN distance datapath.
// Pure declarations: no logic, no latency, no flow control.
package knn_pkg;

  localparam int SUM_LEN_DEF  = 10;
  localparam int LBL_LEN_DEF  = 10;
  localparam int FEAT_LEN_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ACC  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/knn_dist_acc_abs_diff.sv
// Unsigned absolute difference |a-b| of two features.
// Purely combinational, zero latency, no flow control.
module abs_diff #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] d_o
);

  assign d_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/knn_dist_acc.sv
// Saturating Manhattan-distance accumulator over N_FEAT feature pairs.
// out_valid one cycle after the last beat; in_ready low while the result waits for out_ready.
module knn_dist_acc
  import knn_pkg::*;
#(
  parameter int SUM_LEN  = SUM_LEN_DEF,
  parameter int LBL_LEN  = LBL_LEN_DEF,
  parameter int FEAT_LEN = FEAT_LEN_DEF,
  parameter int N_FEAT   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FEAT_LEN-1:0] in_featq,
  input  logic [FEAT_LEN-1:0] in_featt,
  input  logic [LBL_LEN-1:0]  in_lbl,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SUM_LEN-1:0]  out_sum,
  output logic [LBL_LEN-1:0]  out_lbl
);

  localparam int CW = $clog2(N_FEAT + 1);
  // One extra bit over the wider operand so the overflow test is exact.
  localparam int EW = ((SUM_LEN > FEAT_LEN) ? SUM_LEN : FEAT_LEN) + 1;
  localparam logic [EW-1:0] SAT = (EW'(1) << SUM_LEN) - EW'(1);

  state_t              state_q, state_d;
  logic [SUM_LEN-1:0]  acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [LBL_LEN-1:0]  lbl_q, lbl_d;
  logic                rdy_q, rdy_d;

  logic                beat;
  logic [FEAT_LEN-1:0] diff;
  logic [EW-1:0]       acc_base, acc_sum;
  logic [SUM_LEN-1:0]  acc_nxt;
  logic [CW-1:0]       cnt_inc;

  abs_diff #(.W(FEAT_LEN)) u_abs_diff (
    .a_i (in_featq),
    .b_i (in_featt),
    .d_o (diff)
  );

  assign beat     = in_valid & in_ready;
  assign acc_base = (state_q == ST_IDLE) ? '0 : EW'(acc_q);
  assign acc_sum  = acc_base + EW'(diff);
  assign acc_nxt  = (acc_sum > SAT) ? SAT[SUM_LEN-1:0] : acc_sum[SUM_LEN-1:0];
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    lbl_d   = lbl_q;
    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          acc_d   = acc_nxt;
          lbl_d   = in_lbl;
          cnt_d   = CW'(1);
          state_d = (N_FEAT == 1) ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (beat) begin
          acc_d = acc_nxt;
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(N_FEAT)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered ready stays low through reset and rises on the first edge after release.
  assign rdy_d = (state_d != ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      lbl_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      lbl_q   <= lbl_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = acc_q;
  assign out_lbl   = lbl_q;

endmodule

// File: tb/tb_knn_dist_acc.sv
// Bench for knn_dist_acc: directed cases plus randomized samples against a sum-of-|q-t| model.
// Two instances: N_FEAT=4 (main) and N_FEAT=5 (saturation).
module tb_knn_dist_acc;

  localparam int SL = 10;
  localparam int LL = 10;
  localparam int FL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FL-1:0] featq = '0;
  logic [FL-1:0] featt = '0;
  logic [LL-1:0] lbl = '0;
  logic          out_ready = 1'b1;
  logic          sel = 1'b0;

  logic          a_valid = 1'b0, a_ready, a_ovld;
  logic [SL-1:0] a_sum;
  logic [LL-1:0] a_lbl;
  logic          b_valid = 1'b0, b_ready, b_ovld;
  logic [SL-1:0] b_sum;
  logic [LL-1:0] b_lbl;

  logic          cur_ready, cur_ovld;
  logic [SL-1:0] cur_sum;
  logic [LL-1:0] cur_lbl;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  knn_dist_acc #(.SUM_LEN(SL), .LBL_LEN(LL), .FEAT_LEN(FL), .N_FEAT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_featq(featq), .in_featt(featt), .in_lbl(lbl),
    .out_valid(a_ovld), .out_ready(out_ready), .out_sum(a_sum), .out_lbl(a_lbl)
  );

  knn_dist_acc #(.SUM_LEN(SL), .LBL_LEN(LL), .FEAT_LEN(FL), .N_FEAT(5)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_featq(featq), .in_featt(featt), .in_lbl(lbl),
    .out_valid(b_ovld), .out_ready(out_ready), .out_sum(b_sum), .out_lbl(b_lbl)
  );

  assign cur_ready = sel ? b_ready : a_ready;
  assign cur_ovld  = sel ? b_ovld  : a_ovld;
  assign cur_sum   = sel ? b_sum   : a_sum;
  assign cur_lbl   = sel ? b_lbl   : a_lbl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic set_valid(input logic v);
    a_valid = v & ~sel;
    b_valid = v & sel;
  endtask

  // Entered and left on a falling edge; in_valid is high across exactly one rising edge with in_ready=1.
  task automatic beat(input int q, input int t, input int l);
    int g = 0;
    while (!cur_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("ready_timeout", 32'(cur_ready), 32'd1);
    featq = FL'(q);
    featt = FL'(t);
    lbl   = LL'(l);
    set_valid(1'b1);
    @(negedge clk);
    set_valid(1'b0);
  endtask

  task automatic wait_out(input int exp_sum, input int exp_lbl, input int hold, input string tag);
    int g = 0;
    while (!cur_ovld && g < 50) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_vld"}, 32'(cur_ovld), 32'd1);
    check({tag, "_sum"}, 32'(cur_sum), 32'(exp_sum));
    check({tag, "_lbl"}, 32'(cur_lbl), 32'(exp_lbl));
    if (hold > 0) begin
      out_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        check({tag, "_hold_vld"}, 32'(cur_ovld), 32'd1);
        check({tag, "_hold_sum"}, 32'(cur_sum), 32'(exp_sum));
        check({tag, "_hold_lbl"}, 32'(cur_lbl), 32'(exp_lbl));
        check({tag, "_hold_rdy"}, 32'(cur_ready), 32'd0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle_vld"}, 32'(cur_ovld), 32'd0);
    check({tag, "_idle_rdy"}, 32'(cur_ready), 32'd1);
  endtask

  // Reference: Manhattan distance of the whole sample, clipped to the sum range.
  task automatic run_sample(input logic s, input int n, input int qa[5], input int ta[5],
                            input int l0, input int lo, input int gapmax, input int hold,
                            input string tag);
    int exp_s = 0;
    sel = s;
    for (int i = 0; i < n; i++) begin
      beat(qa[i], ta[i], (i == 0) ? l0 : lo);
      exp_s += (qa[i] > ta[i]) ? qa[i] - ta[i] : ta[i] - qa[i];
      if (gapmax > 0 && i < n - 1) repeat ($urandom_range(0, gapmax)) @(negedge clk);
    end
    if (exp_s > (1 << SL) - 1) exp_s = (1 << SL) - 1;
    wait_out(exp_s, l0, hold, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int qb[5];
    int tb[5];
    int c0;

    qb[0] = 10; qb[1] = 20; qb[2] = 30; qb[3] = 40; qb[4] = 0;
    tb[0] = 12; tb[1] = 15; tb[2] = 30; tb[3] = 50; tb[4] = 0;

    #2;
    check("rst_rdy", 32'(a_ready), 32'd0);
    check("rst_vld", 32'(a_ovld), 32'd0);
    check("rst_sum", 32'(a_sum), 32'd0);
    check("rst_lbl", 32'(a_lbl), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_rdy", 32'(a_ready), 32'd1);

    // Back-to-back beats: distance 2+5+0+10.
    sel = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("basic_early", 32'(a_ovld), 32'd0);
      beat(qb[i], tb[i], 7);
    end
    check("basic_lat", 32'(cyc - c0), 32'd4);
    wait_out(17, 7, 0, "basic");

    // Two idle cycles between beats 2 and 3.
    c0 = cyc;
    beat(qb[0], tb[0], 7);
    beat(qb[1], tb[1], 7);
    repeat (2) @(negedge clk);
    beat(qb[2], tb[2], 7);
    beat(qb[3], tb[3], 7);
    check("gap_lat", 32'(cyc - c0), 32'd6);
    wait_out(17, 7, 0, "gap");

    run_sample(1'b0, 4, qb, tb, 7, 7, 0, 3, "bp");

    // Label is captured only on the first beat.
    run_sample(1'b0, 4, qb, tb, 5, 9, 0, 0, "lbl");

    for (int i = 0; i < 5; i++) begin qb[i] = 255; tb[i] = 0; end
    run_sample(1'b1, 5, qb, tb, 1, 1, 0, 0, "sat");

    // Reset in the middle of a sample.
    sel = 1'b0;
    beat(50, 0, 12);
    beat(60, 0, 12);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdy", 32'(a_ready), 32'd0);
    check("mid_rst_sum", 32'(a_sum), 32'd0);
    check("mid_rst_vld", 32'(a_ovld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_rdy", 32'(a_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin qb[i] = 1; tb[i] = 0; end
    run_sample(1'b0, 4, qb, tb, 3, 3, 0, 0, "after_rst");

    for (int k = 0; k < 16; k++) begin
      logic s;
      s = k[0];
      for (int i = 0; i < 5; i++) begin
        if (s) begin
          qb[i] = $urandom_range(120, 255);
          tb[i] = $urandom_range(0, 100);
        end else begin
          qb[i] = $urandom_range(0, 255);
          tb[i] = $urandom_range(0, 255);
        end
      end
      run_sample(s, s ? 5 : 4, qb, tb, $urandom_range(0, 1023), $urandom_range(0, 1023),
                 2, $urandom_range(0, 2), s ? "rnd_sat" : "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/knn_dist_acc.md
KNN_DIST_ACC -- requirements
Module: knn_dist_acc

Interface
REQ-001 SHALL have parameter SUM_LEN, default 10, width of the distance sum.
REQ-002 SHALL have parameter LBL_LEN, default 10, width of the sample label.
REQ-003 SHALL have parameter FEAT_LEN, default 8, width of one unsigned feature.
REQ-004 SHALL have parameter N_FEAT, default 4, number of features per sample (>=1).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  feature pair valid.
REQ-008 SHALL have port in_ready  output  1  block accepts a feature pair.
REQ-009 SHALL have port in_featq  input  FEAT_LEN  query feature.
REQ-010 SHALL have port in_featt  input  FEAT_LEN  training-sample feature.
REQ-011 SHALL have port in_lbl  input  LBL_LEN  sample label, sampled with the first feature only.
REQ-012 SHALL have port out_valid  output  1  distance result valid.
REQ-013 SHALL have port out_ready  input  1  downstream comparator stage accepts the result.
REQ-014 SHALL have port out_sum  output  SUM_LEN  Manhattan distance, feeds the comparator sum input.
REQ-015 SHALL have port out_lbl  output  LBL_LEN  label paired with out_sum.

Function
REQ-016 SHALL implement FSM states IDLE, ACC, DONE.
REQ-017 SHALL accept a feature pair only on a cycle where in_valid and in_ready are both 1 (a "beat").
REQ-018 SHALL drive in_ready=1 in IDLE and ACC, 0 in DONE.
REQ-019 SHALL, on a beat in IDLE: load acc=|in_featq-in_featt|, latch in_lbl, set cnt=1, go to ACC (or DONE if N_FEAT=1).
REQ-020 SHALL, on a beat in ACC: acc=acc+|in_featq-in_featt|, cnt=cnt+1; go to DONE on the beat where cnt reaches N_FEAT.
REQ-021 SHALL hold acc, cnt and state unchanged on cycles without a beat (in_valid gaps allowed anywhere).
REQ-022 SHALL compute |a-b| as unsigned, zero-extended to SUM_LEN before addition.
REQ-023 SHALL saturate acc at 2^SUM_LEN-1; once saturated it stays saturated until the sample completes.
REQ-024 SHALL drive out_valid=1 exactly while in DONE; out_sum/out_lbl stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, in DONE with out_ready=1, return to IDLE next cycle; no new beat accepted in that same cycle.
REQ-026 SHALL give latency: out_valid rises the cycle after the N_FEAT-th beat.
REQ-027 SHALL ignore in_lbl on non-first beats.

Reset
REQ-028 SHALL on rst_n=0 immediately force state=IDLE, acc=0, cnt=0, latched label=0, out_valid=0, out_sum=0, out_lbl=0, in_ready=0 while rst_n=0.
REQ-029 SHALL discard any partial sample when reset asserts mid-accumulation; first beat after release starts a new sample.
REQ-030 SHALL raise in_ready in the first clock edge after rst_n deasserts.

Structure
REQ-031 SHALL take SUM_LEN, LBL_LEN, FEAT_LEN defaults and FSM state encoding from shared package knn_pkg.
REQ-032 SHALL instantiate one sub-module abs_diff (combinational |a-b|, FEAT_LEN wide).
REQ-033 SHALL keep cnt width ceil(log2(N_FEAT+1)).

Verification
REQ-034 SHALL test basic: q=(10,20,30,40), t=(12,15,30,50), lbl=7, back-to-back beats -> out_sum=17, out_lbl=7, out_valid one cycle after 4th beat.
REQ-035 SHALL test gaps: same data with in_valid low 2 cycles between beats 2 and 3 -> out_sum=17, out_valid 2 cycles later than in REQ-034.
REQ-036 SHALL test backpressure: out_ready=0 for 3 cycles in DONE -> out_valid, out_sum=17, out_lbl=7 held, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-037 SHALL test saturation: N_FEAT=5, q=255, t=0 each beat -> out_sum=1023.
REQ-038 SHALL test reset mid-op: rst_n=0 after 2 beats, then full sample q=(1,1,1,1), t=(0,0,0,0), lbl=3 -> out_sum=4, out_lbl=3.
REQ-039 SHALL test label latch: in_lbl changes 5->9 after first beat -> out_lbl=5.
